dm_port_arbiter: RTL and testbench

Shares the single data memory (DM) between the CPU MEM stage and a loader/debug port. The CPU keeps fixed priority, and a starvation guard forces a loader slot after a bounded wait. The block drives the DM command bus (`DM_write`, `DMop`, `DM_addr`, `DM_WD`) and steers `DMout` back to the granted requester. It sits between the MEM-stage pipeline register and the `DM` instance.

---
 rtl/dm_port_arbiter_pkg.sv | 22 ++
 rtl/dm_port_arbiter_if.sv | 46 ++++
 rtl/dm_port_arbiter_starve_guard.sv | 45 ++++
 rtl/dm_port_arbiter.sv | 83 ++++++++
 tb/tb_dm_port_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/dm_port_arbiter_pkg.sv
// Shared encodings and helpers for the data-memory port arbiter and the DM itself.
package dm_pkg;

  localparam logic [1:0] DMOP_W = 2'd0;
  localparam logic [1:0] DMOP_H = 2'd1;
  localparam logic [1:0] DMOP_B = 2'd2;

  typedef enum logic {
    S_NORM  = 1'b0,
    S_FORCE = 1'b1
  } arb_state_e;

  // Only the two low address bits matter; reserved op 3 is checked as a word.
  function automatic logic dm_misaligned(input logic [1:0] op, input logic [1:0] addr);
    case (op)
      DMOP_H:  return addr[0];
      DMOP_B:  return 1'b0;
      default: return (addr != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// CPU, loader and DM command/response signals shared by the arbiter and its environment.
interface dm_port_arbiter_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_op;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        ld_valid;
  logic        ld_ready;
  logic        ld_we;
  logic [1:0]  ld_op;
  logic [31:0] ld_addr;
  logic [31:0] ld_wd;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        ld_err;

  logic        DM_write;
  logic [1:0]  DMop;
  logic [31:0] DM_addr;
  logic [31:0] DM_WD;
  logic [31:0] DMout;

  modport slave (
    input  cpu_req, cpu_we, cpu_op, cpu_addr, cpu_wd,
    input  ld_valid, ld_we, ld_op, ld_addr, ld_wd,
    input  DMout,
    output cpu_rdata, cpu_stall,
    output ld_ready, ld_rvalid, ld_rdata, ld_err,
    output DM_write, DMop, DM_addr, DM_WD
  );

  modport master (
    output cpu_req, cpu_we, cpu_op, cpu_addr, cpu_wd,
    output ld_valid, ld_we, ld_op, ld_addr, ld_wd,
    output DMout,
    input  cpu_rdata, cpu_stall,
    input  ld_ready, ld_rvalid, ld_rdata, ld_err,
    input  DM_write, DMop, DM_addr, DM_WD
  );

endinterface

// File: rtl/dm_port_arbiter_starve_guard.sv
// Loader starvation guard: counts loader wait cycles and forces a loader slot when they run out.
module dm_starve_guard
  import dm_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic ld_valid_i,
  input  logic ld_ready_i,
  output logic force_ld_o
);

  localparam logic [3:0] WMAX = 4'(STARVE_MAX);

  arb_state_e state_q;
  logic [3:0] wcnt_q;
  logic       ld_hs;
  logic       ld_wait;

  assign ld_hs   = ld_valid_i && ld_ready_i;
  assign ld_wait = ld_valid_i && !ld_ready_i;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= S_NORM;
      wcnt_q  <= '0;
    end else begin
      if (!ld_valid_i || ld_hs) begin
        wcnt_q <= '0;
      end else if (wcnt_q != WMAX) begin
        wcnt_q <= wcnt_q + 4'd1;
      end

      case (state_q)
        S_NORM:  if (ld_wait && (wcnt_q == WMAX - 4'd1)) state_q <= S_FORCE;
        S_FORCE: if (ld_hs || !ld_valid_i) state_q <= S_NORM;
        default: state_q <= S_NORM;
      endcase
    end
  end

  assign force_ld_o = (state_q == S_FORCE);

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the data memory between the CPU MEM stage (fixed priority) and a loader/debug port.
module dm_port_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic              clk,
  input logic              reset,
  dm_port_arbiter_if.slave bus
);

  logic        force_ld;
  logic        cpu_gnt;
  logic        ld_gnt;
  logic        ld_mis;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  assign ld_mis  = dm_misaligned(bus.ld_op, bus.ld_addr[1:0]);
  // Reset gates both grants so a store in flight when reset asserts never reaches the DM.
  assign cpu_gnt = reset && bus.cpu_req && !force_ld;
  assign ld_gnt  = reset && bus.ld_valid && (force_ld || !bus.cpu_req);

  dm_starve_guard #(
    .STARVE_MAX(STARVE_MAX)
  ) u_guard (
    .clk_i     (clk),
    .reset_i   (reset),
    .ld_valid_i(bus.ld_valid),
    .ld_ready_i(ld_gnt),
    .force_ld_o(force_ld)
  );

  always_comb begin
    bus.DM_write = 1'b0;
    bus.DMop     = '0;
    bus.DM_addr  = '0;
    bus.DM_WD    = '0;
    if (cpu_gnt) begin
      bus.DM_write = bus.cpu_we;
      bus.DMop     = bus.cpu_op;
      bus.DM_addr  = bus.cpu_addr;
      bus.DM_WD    = bus.cpu_wd;
    end else if (ld_gnt) begin
      bus.DM_write = bus.ld_we && !ld_mis;
      bus.DMop     = bus.ld_op;
      bus.DM_addr  = bus.ld_addr;
      bus.DM_WD    = bus.ld_wd;
    end
  end

  assign bus.cpu_rdata = cpu_gnt ? bus.DMout : '0;
  assign bus.cpu_stall = reset && bus.cpu_req && force_ld;
  assign bus.ld_ready  = ld_gnt;

  always_comb begin
    rvalid_d = ld_gnt;
    err_d    = err_q;
    rdata_d  = rdata_q;
    if (ld_gnt) begin
      err_d   = ld_mis;
      rdata_d = ld_mis ? '0 : bus.DMout;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.ld_rvalid = rvalid_q;
  assign bus.ld_err    = err_q;
  assign bus.ld_rdata  = rdata_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural DM model (little-endian lanes).
module tb_dm_port_arbiter;
  import dm_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mem_clear = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dm_port_arbiter_if bus ();

  dm_port_arbiter #(
    .STARVE_MAX(4)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] mem [16];

  assign bus.DMout = mem[bus.DM_addr[5:2]];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int unsigned i = 0; i < 16; i++) mem[i] <= '0;
    end else if (bus.DM_write) begin
      case (bus.DMop)
        2'd2:    mem[bus.DM_addr[5:2]][{bus.DM_addr[1:0], 3'b000} +: 8] <= bus.DM_WD[7:0];
        2'd1:    mem[bus.DM_addr[5:2]][{bus.DM_addr[1], 4'b0000} +: 16] <= bus.DM_WD[15:0];
        default: mem[bus.DM_addr[5:2]] <= bus.DM_WD;
      endcase
    end
  end

  typedef struct {
    logic        cr, cw;
    logic [1:0]  cop;
    logic [31:0] ca, cd;
    logic        lv, lw;
    logic [1:0]  lop;
    logic [31:0] la, ld;
    logic        e_stall, e_ready, e_dmw;
    logic [31:0] e_addr, e_crd;
    logic        e_rv, e_err;
    logic [31:0] e_lrd;
  } vec_t;

  localparam int unsigned NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [1:0] cop, input logic [31:0] ca, input logic [31:0] cd,
    input logic lv, input logic lw, input logic [1:0] lop, input logic [31:0] la, input logic [31:0] ld,
    input logic es, input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ec,
    input logic erv, input logic eerr, input logic [31:0] elrd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.cop = cop; v.ca = ca; v.cd = cd;
    v.lv = lv; v.lw = lw; v.lop = lop; v.la = la; v.ld = ld;
    v.e_stall = es; v.e_ready = er; v.e_dmw = ew; v.e_addr = ea; v.e_crd = ec;
    v.e_rv = erv; v.e_err = eerr; v.e_lrd = elrd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(
    input logic cr, input logic cw, input logic [1:0] cop, input logic [31:0] ca, input logic [31:0] cd,
    input logic lv, input logic lw, input logic [1:0] lop, input logic [31:0] la, input logic [31:0] ld);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_op = cop; bus.cpu_addr = ca; bus.cpu_wd = cd;
    bus.ld_valid = lv; bus.ld_we = lw; bus.ld_op = lop; bus.ld_addr = la; bus.ld_wd = ld;
  endtask

  initial begin
    set_in(1'b1, 1'b1, 2'd0, 32'h0, 32'h99, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

    // Reset held for two cycles with a CPU store pending.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #2;
      chk("rst_dm_write", 32'(bus.DM_write), 32'h0);
      chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'h0);
      chk("rst_ld_ready", 32'(bus.ld_ready), 32'h0);
      @(posedge clk);
      #1;
      chk("rst_ld_rvalid", 32'(bus.ld_rvalid), 32'h0);
      chk("rst_ld_rdata", bus.ld_rdata, 32'h0);
      chk("rst_ld_err", 32'(bus.ld_err), 32'h0);
      chk("rst_wcnt", 32'(u_dut.u_guard.wcnt_q), 32'h0);
    end
    @(negedge clk);
    mem_clear = 1'b0;
    reset = 1'b1;

    //                 cr    cw    cop   ca     cd             lv    lw    lop   la     ld             stall ready dmw   addr   cpu_rdata      rv    err   ld_rdata
    vecs[0]  = mk(1'b1, 1'b1, 2'd0, 32'h0, 32'habcd5555, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0);
    vecs[1]  = mk(1'b1, 1'b0, 2'd0, 32'h0, 32'h0,        1'b0, 1'b0, 2'd0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0, 32'habcd5555, 1'b0, 1'b0, 32'h0);
    vecs[2]  = mk(1'b0, 1'b0, 2'd0, 32'h0, 32'h0,        1'b1, 1'b1, 2'd2, 32'h0, 32'hfe,       1'b0, 1'b1, 1'b1, 32'h0, 32'h0,        1'b1, 1'b0, 32'habcd5555);
    vecs[3]  = mk(1'b1, 1'b0, 2'd0, 32'h0, 32'h0,        1'b0, 1'b0, 2'd0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0, 32'habcd55fe, 1'b0, 1'b0, 32'h0);
    vecs[4]  = mk(1'b1, 1'b1, 2'd0, 32'h4, 32'h12345678, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h4, 32'h0,        1'b0, 1'b0, 32'h0);
    vecs[5]  = mk(1'b0, 1'b0, 2'd0, 32'h0, 32'h0,        1'b1, 1'b1, 2'd0, 32'h6, 32'hdeadbeef, 1'b0, 1'b1, 1'b0, 32'h6, 32'h0,        1'b1, 1'b1, 32'h0);
    vecs[6]  = mk(1'b1, 1'b0, 2'd0, 32'h4, 32'h0,        1'b0, 1'b0, 2'd0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h4, 32'h12345678, 1'b0, 1'b0, 32'h0);
    vecs[7]  = mk(1'b0, 1'b0, 2'd0, 32'h0, 32'h0,        1'b1, 1'b0, 2'd0, 32'h0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'habcd55fe);
    vecs[8]  = mk(1'b0, 1'b0, 2'd0, 32'h0, 32'h0,        1'b1, 1'b0, 2'd0, 32'h4, 32'h0,        1'b0, 1'b1, 1'b0, 32'h4, 32'h0,        1'b1, 1'b0, 32'h12345678);
    vecs[9]  = mk(1'b1, 1'b0, 2'd0, 32'h4, 32'h0,        1'b1, 1'b0, 2'd0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h4, 32'h12345678, 1'b0, 1'b0, 32'h0);
    vecs[10] = mk(1'b0, 1'b0, 2'd0, 32'h4, 32'h55,       1'b0, 1'b1, 2'd0, 32'h8, 32'h66,       1'b0, 1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0);
    vecs[11] = mk(1'b0, 1'b0, 2'd0, 32'h0, 32'h0,        1'b1, 1'b1, 2'd1, 32'h2, 32'h0000beef, 1'b0, 1'b1, 1'b1, 32'h2, 32'h0,        1'b1, 1'b0, 32'habcd55fe);
    vecs[12] = mk(1'b0, 1'b0, 2'd0, 32'h0, 32'h0,        1'b1, 1'b0, 2'd1, 32'h1, 32'h0,        1'b0, 1'b1, 1'b0, 32'h1, 32'h0,        1'b1, 1'b1, 32'h0);
    vecs[13] = mk(1'b1, 1'b0, 2'd0, 32'h0, 32'h0,        1'b0, 1'b0, 2'd0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0, 32'hbeef55fe, 1'b0, 1'b0, 32'h0);
    vecs[14] = mk(1'b1, 1'b1, 2'd3, 32'h8, 32'h11,       1'b0, 1'b0, 2'd0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h8, 32'h0,        1'b0, 1'b0, 32'h0);
    vecs[15] = mk(1'b0, 1'b0, 2'd0, 32'h0, 32'h0,        1'b1, 1'b1, 2'd2, 32'h3, 32'h5a,       1'b0, 1'b1, 1'b1, 32'h3, 32'h0,        1'b1, 1'b0, 32'hbeef55fe);
    vecs[16] = mk(1'b1, 1'b0, 2'd0, 32'h0, 32'h0,        1'b0, 1'b0, 2'd0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0, 32'h5aef55fe, 1'b0, 1'b0, 32'h0);

    for (int unsigned i = 0; i < NV; i++) begin
      set_in(vecs[i].cr, vecs[i].cw, vecs[i].cop, vecs[i].ca, vecs[i].cd,
             vecs[i].lv, vecs[i].lw, vecs[i].lop, vecs[i].la, vecs[i].ld);
      #2;
      chk($sformatf("v%0d_cpu_stall", i), 32'(bus.cpu_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_ld_ready", i), 32'(bus.ld_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_dm_write", i), 32'(bus.DM_write), 32'(vecs[i].e_dmw));
      chk($sformatf("v%0d_dm_addr", i), bus.DM_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_cpu_rdata", i), bus.cpu_rdata, vecs[i].e_crd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ld_rvalid", i), 32'(bus.ld_rvalid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) begin
        chk($sformatf("v%0d_ld_err", i), 32'(bus.ld_err), 32'(vecs[i].e_err));
        chk($sformatf("v%0d_ld_rdata", i), bus.ld_rdata, vecs[i].e_lrd);
      end
      @(negedge clk);
    end

    // Starvation: CPU loads continuously, loader waits four cycles then gets a forced slot.
    for (int c = 0; c < 6; c++) begin
      set_in(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 2'd0, 32'h4, 32'h0);
      #2;
      chk($sformatf("starve%0d_ld_ready", c), 32'(bus.ld_ready), (c == 4) ? 32'h1 : 32'h0);
      chk($sformatf("starve%0d_cpu_stall", c), 32'(bus.cpu_stall), (c == 4) ? 32'h1 : 32'h0);
      chk($sformatf("starve%0d_cpu_rdata", c), bus.cpu_rdata, (c == 4) ? 32'h0 : 32'h5aef55fe);
      chk($sformatf("starve%0d_dm_addr", c), bus.DM_addr, (c == 4) ? 32'h4 : 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("starve%0d_ld_rvalid", c), 32'(bus.ld_rvalid), (c == 4) ? 32'h1 : 32'h0);
      if (c == 4) chk("starve_ld_rdata", bus.ld_rdata, 32'h12345678);
      @(negedge clk);
    end
    set_in(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk("idle_wcnt", 32'(u_dut.u_guard.wcnt_q), 32'h0);
    @(negedge clk);

    // Reset lands in the first forced cycle, together with a CPU store to addr 12.
    for (int c = 0; c < 4; c++) begin
      set_in(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 2'd0, 32'h4, 32'h0);
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0;
    set_in(1'b1, 1'b1, 2'd0, 32'hc, 32'h77, 1'b1, 1'b0, 2'd0, 32'h4, 32'h0);
    #2;
    chk("rf_state_forced", 32'(u_dut.u_guard.state_q == S_FORCE), 32'h1);
    chk("rf_ld_ready", 32'(bus.ld_ready), 32'h0);
    chk("rf_cpu_stall", 32'(bus.cpu_stall), 32'h0);
    chk("rf_dm_write", 32'(bus.DM_write), 32'h0);
    @(posedge clk);
    #1;
    chk("rf_ld_rvalid", 32'(bus.ld_rvalid), 32'h0);
    chk("rf_state_norm", 32'(u_dut.u_guard.state_q == S_NORM), 32'h1);
    chk("rf_wcnt", 32'(u_dut.u_guard.wcnt_q), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    set_in(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk("rf_post_rvalid", 32'(bus.ld_rvalid), 32'h0);
    chk("rf_post_state", 32'(u_dut.u_guard.state_q == S_NORM), 32'h1);
    chk("rf_post_wcnt", 32'(u_dut.u_guard.wcnt_q), 32'h0);
    @(negedge clk);
    set_in(1'b1, 1'b0, 2'd0, 32'hc, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    #2;
    chk("rf_store_suppressed", bus.cpu_rdata, 32'h0);
    chk("rf_cpu_stall_after", 32'(bus.cpu_stall), 32'h0);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
